// File: rtl/uart_frame_pkg.sv
// Shared constants and state encoding for the UART frame parser.
package uart_frame_pkg;

  localparam logic [7:0] HDR0_DEFAULT = 8'h55;
  localparam logic [7:0] HDR1_DEFAULT = 8'hAA;

  localparam logic [1:0] ERR_LEN = 2'd0;
  localparam logic [1:0] ERR_CHK = 2'd1;
  localparam logic [1:0] ERR_TMO = 2'd2;
  localparam logic [1:0] ERR_OVF = 2'd3;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    HDR1  = 3'd1,
    LEN   = 3'd2,
    DATA  = 3'd3,
    CHK   = 3'd4,
    DRAIN = 3'd5
  } state_e;

endpackage

// File: rtl/uart_frame_buf.sv
// Payload register file: synchronous write, asynchronous read so the drained
// byte is available in the same cycle the read pointer changes.
module uart_frame_buf #(
  parameter int P_DEPTH = 16,
  parameter int P_AW    = $clog2(P_DEPTH + 1)
) (
  input  logic            clk_i,
  input  logic            we_i,
  input  logic [P_AW-1:0] waddr_i,
  input  logic [7:0]      wdata_i,
  input  logic [P_AW-1:0] raddr_i,
  output logic [7:0]      rdata_o
);

  logic [7:0] mem_q [P_DEPTH];

  for (genvar gi = 0; gi < P_DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk_i) begin
      if (we_i && (waddr_i == P_AW'(gi))) begin
        mem_q[gi] <= wdata_i;
      end
    end
  end

  // Address width can exceed the depth, so out-of-range reads return zero.
  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < P_DEPTH; i++) begin
      if (raddr_i == P_AW'(i)) rdata_o = mem_q[i];
    end
  end

endmodule

// File: rtl/uart_frame_parser.sv
// Finds HDR0/HDR1/LEN/payload/CHK frames in a UART byte stream, buffers the
// payload and releases it on a valid/ready stream once the checksum matches.
module uart_frame_parser
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] P_HDR0    = HDR0_DEFAULT,
  parameter logic [7:0] P_HDR1    = HDR1_DEFAULT,
  parameter int         P_MAX_LEN = 16,
  parameter int         P_TIMEOUT = 64
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [7:0]  i_rx_data,
  input  logic        i_rx_valid,
  output logic [7:0]  o_m_data,
  output logic        o_m_valid,
  output logic        o_m_last,
  input  logic        i_m_ready,
  output logic        o_frame_ok,
  output logic        o_err_valid,
  output logic [1:0]  o_err_code,
  output logic [15:0] o_frame_cnt,
  output logic        o_busy
);

  localparam int CW = $clog2(P_MAX_LEN + 1);
  localparam int TW = $clog2(P_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(P_TIMEOUT - 1);
  localparam logic [7:0]    MAX_LEN8 = 8'(P_MAX_LEN);

  state_e        state_q, state_d;
  logic [7:0]    len_q, len_d;
  logic [7:0]    sum_q, sum_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_cnt_q, rd_cnt_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [15:0]   frame_cnt_q, frame_cnt_d;
  logic          frame_ok_q, frame_ok_d;
  logic          err_valid_q, err_valid_d;
  logic [1:0]    err_code_q, err_code_d;

  logic          buf_we;
  logic [7:0]    buf_rdata;
  logic          timed;
  logic          tmo_hit;
  logic          last_beat;
  logic          draining;

  uart_frame_buf #(
    .P_DEPTH (P_MAX_LEN),
    .P_AW    (CW)
  ) u_buf (
    .clk_i   (i_clk),
    .we_i    (buf_we),
    .waddr_i (wr_cnt_q),
    .wdata_i (i_rx_data),
    .raddr_i (rd_cnt_q),
    .rdata_o (buf_rdata)
  );

  assign draining  = (state_q == DRAIN);
  assign timed     = state_q inside {HDR1, LEN, DATA, CHK};
  // A byte arriving in the expiry cycle wins, hence the !i_rx_valid term.
  assign tmo_hit   = timed && !i_rx_valid && (idle_q == TMO_LAST);
  assign last_beat = (8'(rd_cnt_q) == (len_q - 8'd1));

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    sum_d       = sum_q;
    wr_cnt_d    = wr_cnt_q;
    rd_cnt_d    = rd_cnt_q;
    frame_cnt_d = frame_cnt_q;
    frame_ok_d  = 1'b0;
    err_valid_d = 1'b0;
    err_code_d  = '0;
    buf_we      = 1'b0;
    idle_d      = (timed && !i_rx_valid) ? idle_q + 1'b1 : '0;

    if (tmo_hit) begin
      err_valid_d = 1'b1;
      err_code_d  = ERR_TMO;
      state_d     = IDLE;
      idle_d      = '0;
    end else begin
      unique case (state_q)
        IDLE: if (i_rx_valid && (i_rx_data == P_HDR0)) state_d = HDR1;
        HDR1: if (i_rx_valid) begin
          if (i_rx_data == P_HDR1)      state_d = LEN;
          else if (i_rx_data != P_HDR0) state_d = IDLE;
        end
        LEN: if (i_rx_valid) begin
          if ((i_rx_data == 8'd0) || (i_rx_data > MAX_LEN8)) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_LEN;
            state_d     = IDLE;
          end else begin
            len_d    = i_rx_data;
            sum_d    = i_rx_data;
            wr_cnt_d = '0;
            state_d  = DATA;
          end
        end
        DATA: if (i_rx_valid) begin
          buf_we   = 1'b1;
          sum_d    = sum_q + i_rx_data;
          wr_cnt_d = wr_cnt_q + 1'b1;
          if (8'(wr_cnt_q) == (len_q - 8'd1)) state_d = CHK;
        end
        CHK: if (i_rx_valid) begin
          if (i_rx_data == sum_q) begin
            frame_ok_d  = 1'b1;
            frame_cnt_d = frame_cnt_q + 16'd1;
            rd_cnt_d    = '0;
            state_d     = DRAIN;
          end else begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_CHK;
            state_d     = IDLE;
          end
        end
        DRAIN: begin
          // No backpressure toward the UART: bytes seen while draining are lost.
          if (i_rx_valid) begin
            err_valid_d = 1'b1;
            err_code_d  = ERR_OVF;
          end
          if (i_m_ready) begin
            rd_cnt_d = rd_cnt_q + 1'b1;
            if (last_beat) state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      len_q       <= '0;
      sum_q       <= '0;
      wr_cnt_q    <= '0;
      rd_cnt_q    <= '0;
      idle_q      <= '0;
      frame_cnt_q <= '0;
      frame_ok_q  <= 1'b0;
      err_valid_q <= 1'b0;
      err_code_q  <= '0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      sum_q       <= sum_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      idle_q      <= idle_d;
      frame_cnt_q <= frame_cnt_d;
      frame_ok_q  <= frame_ok_d;
      err_valid_q <= err_valid_d;
      err_code_q  <= err_code_d;
    end
  end

  assign o_m_valid   = draining;
  assign o_m_data    = draining ? buf_rdata : 8'd0;
  assign o_m_last    = draining && last_beat;
  assign o_frame_ok  = frame_ok_q;
  assign o_err_valid = err_valid_q;
  assign o_err_code  = err_code_q;
  assign o_frame_cnt = frame_cnt_q;
  assign o_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_frame_parser.sv
// Scenario and randomized checks of uart_frame_parser against a frame-level model.
module tb_uart_frame_parser;

  localparam int MAX_LEN = 16;
  localparam int TMO     = 64;

  typedef logic [7:0] byte_q_t[$];

  logic        clk = 1'b0;
  logic        rst, rx_valid, m_ready;
  logic [7:0]  rx_data;
  logic [7:0]  m_data;
  logic        m_valid, m_last, frame_ok, err_valid, busy;
  logic [1:0]  err_code;
  logic [15:0] frame_cnt;

  always #5 clk = ~clk;

  uart_frame_parser #(
    .P_HDR0(8'h55), .P_HDR1(8'hAA), .P_MAX_LEN(MAX_LEN), .P_TIMEOUT(TMO)
  ) dut (
    .i_clk(clk), .i_rst(rst), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_m_data(m_data), .o_m_valid(m_valid), .o_m_last(m_last), .i_m_ready(m_ready),
    .o_frame_ok(frame_ok), .o_err_valid(err_valid), .o_err_code(err_code),
    .o_frame_cnt(frame_cnt), .o_busy(busy)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int exp_frame_cnt = 0;

  // Observations collected on the falling edge.
  logic [8:0] out_q[$];
  logic [1:0] err_q[$];
  int ok_cnt, hold_viol, both_cnt;
  bit rand_ready = 1'b0;

  initial begin
    bit prev_stall = 1'b0;
    logic [7:0] prev_data = '0;
    logic prev_last = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) hold_viol++;
        prev_stall = m_valid && !m_ready;
        prev_data  = m_data;
        prev_last  = m_last;
        if (m_valid && m_ready) out_q.push_back({m_last, m_data});
        if (frame_ok) ok_cnt++;
        if (err_valid) err_q.push_back(err_code);
        if (frame_ok && err_valid) both_cnt++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  // Checksum as the frame format defines it: LEN plus payload, modulo 256.
  function automatic logic [7:0] model_chk(input byte_q_t p);
    int s;
    s = p.size();
    foreach (p[i]) s += int'(p[i]);
    return 8'(s % 256);
  endfunction

  // Number of differences between observed beats and the payload expected out.
  function automatic int beat_diffs(input byte_q_t p);
    int d;
    d = (out_q.size() == p.size()) ? 0 : 1;
    foreach (p[i]) begin
      if (i < out_q.size()) begin
        if (out_q[i] !== {(i == p.size() - 1), p[i]}) d++;
      end
    end
    return d;
  endfunction

  task automatic clear_obs();
    out_q.delete();
    err_q.delete();
    ok_cnt = 0;
    hold_viol = 0;
    both_cnt = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame(input byte_q_t p, input logic [7:0] chk_xor, input int max_gap);
    byte_q_t f;
    f.push_back(8'h55);
    f.push_back(8'hAA);
    f.push_back(8'(p.size()));
    foreach (p[i]) f.push_back(p[i]);
    f.push_back(model_chk(p) ^ chk_xor);
    foreach (f[i]) begin
      send_byte(f[i]);
      if (max_gap > 0) repeat ($urandom_range(0, max_gap)) begin @(posedge clk); #1; end
    end
  endtask

  task automatic wait_idle(input int max_cycles, output bit timed_out);
    int n = 0;
    while (busy && n < max_cycles) begin
      if (rand_ready) m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    timed_out = busy;
    m_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; m_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if ({m_data, m_valid, m_last, frame_ok, err_valid, err_code, frame_cnt, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got data=%h v=%b l=%b ok=%b ev=%b ec=%0d cnt=%0d busy=%b, expected all zero",
               m_data, m_valid, m_last, frame_ok, err_valid, err_code, frame_cnt, busy);
    end
    rst = 1'b0;
    exp_frame_cnt = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame();
    byte_q_t p = '{8'h11, 8'h22, 8'h33};
    byte_q_t f = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    clear_obs();
    m_ready = 1'b1;
    foreach (f[i]) send_byte(f[i]);
    exp_frame_cnt++;
    tests_run++;
    if (frame_ok !== 1'b1 || m_valid !== 1'b1) begin
      tests_failed++;
      $display("FAIL good_latency: got ok=%b valid=%b, expected 1 1 in cycle after CHK", frame_ok, m_valid);
    end
    foreach (p[i]) begin
      tests_run++;
      if ({m_valid, m_last, m_data} !== {1'b1, (i == 2), p[i]}) begin
        tests_failed++;
        $display("FAIL good_beat%0d: got v=%b l=%b d=%h, expected v=1 l=%b d=%h",
                 i, m_valid, m_last, m_data, (i == 2), p[i]);
      end
      @(posedge clk); #1;
    end
    tests_run++;
    if (m_valid !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("FAIL good_end: got valid=%b busy=%b, expected 0 0", m_valid, busy);
    end
    tests_run++;
    if (frame_cnt !== 16'(exp_frame_cnt) || ok_cnt !== 1 || err_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL good_counts: got cnt=%0d ok_pulses=%0d errs=%0d, expected cnt=%0d ok_pulses=1 errs=0",
               frame_cnt, ok_cnt, err_q.size(), exp_frame_cnt);
    end
    $display("[TB] good frame: %0d bytes drained, frame_cnt=%0d", p.size(), frame_cnt);
  endtask

  task automatic test_bad_chk();
    byte_q_t f = '{8'h55, 8'hAA, 8'h03, 8'h11, 8'h22, 8'h33, 8'h68};
    bit to;
    int vseen = 0;
    clear_obs();
    foreach (f[i]) send_byte(f[i]);
    repeat (4) begin if (m_valid) vseen++; @(posedge clk); #1; end
    wait_idle(10, to);
    tests_run++;
    if (err_q.size() !== 1 || (err_q.size() == 1 && err_q[0] !== 2'd1)) begin
      tests_failed++;
      $display("FAIL bad_chk_err: got %0d error pulses (first code %0d), expected one pulse code 1",
               err_q.size(), (err_q.size() > 0) ? err_q[0] : 2'd0);
    end
    tests_run++;
    if (vseen !== 0 || out_q.size() !== 0 || ok_cnt !== 0 || frame_cnt !== 16'(exp_frame_cnt)) begin
      tests_failed++;
      $display("FAIL bad_chk_out: got valid_cycles=%0d beats=%0d ok=%0d cnt=%0d, expected 0 0 0 %0d",
               vseen, out_q.size(), ok_cnt, frame_cnt, exp_frame_cnt);
    end
    $display("[TB] bad checksum frame rejected, errors=%0d", err_q.size());
  endtask

  task automatic test_len_bounds();
    byte_q_t lens = '{8'h00, 8'h11};
    byte_q_t p;
    bit to;
    foreach (lens[i]) begin
      clear_obs();
      send_byte(8'h55); send_byte(8'hAA); send_byte(lens[i]);
      @(posedge clk); #1;
      tests_run++;
      if (err_q.size() !== 1 || (err_q.size() == 1 && err_q[0] !== 2'd0) || busy !== 1'b0) begin
        tests_failed++;
        $display("FAIL len_bad_%h: got errs=%0d code=%0d busy=%b, expected one code 0 and idle",
                 lens[i], err_q.size(), (err_q.size() > 0) ? err_q[0] : 2'd0, busy);
      end
      $display("[TB] length %h rejected", lens[i]);
    end
    clear_obs();
    for (int i = 0; i < MAX_LEN; i++) p.push_back(8'($urandom));
    send_frame(p, 8'h00, 0);
    exp_frame_cnt++;
    wait_idle(100, to);
    tests_run++;
    if (to || beat_diffs(p) !== 0 || ok_cnt !== 1 || err_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL len_max: got timeout=%b beats=%0d diffs=%0d ok=%0d errs=%0d, expected 0 %0d 0 1 0",
               to, out_q.size(), beat_diffs(p), ok_cnt, err_q.size(), MAX_LEN);
    end
    $display("[TB] max length frame: %0d bytes drained", out_q.size());
  endtask

  task automatic test_timeout_resync();
    byte_q_t r = '{8'h55, 8'h55, 8'hAA, 8'h01, 8'h7E, 8'h7F};
    int first_k = -1;
    logic [1:0] code = '0;
    bit to;
    clear_obs();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h02); send_byte(8'h11);
    // Error is expected to register on the TMO-th edge after the edge that took 0x11.
    for (int k = 1; k <= TMO + 10; k++) begin
      @(posedge clk); #1;
      if (err_valid && first_k < 0) begin first_k = k; code = err_code; end
    end
    tests_run++;
    if (first_k !== TMO || code !== 2'd2) begin
      tests_failed++;
      $display("FAIL timeout_edge: got err after %0d edges code %0d, expected %0d edges code 2",
               first_k, code, TMO);
    end
    tests_run++;
    if (busy !== 1'b0 || err_q.size() !== 1) begin
      tests_failed++;
      $display("FAIL timeout_state: got busy=%b errs=%0d, expected 0 1", busy, err_q.size());
    end
    clear_obs();
    foreach (r[i]) send_byte(r[i]);
    exp_frame_cnt++;
    wait_idle(20, to);
    tests_run++;
    if (out_q.size() !== 1 || (out_q.size() == 1 && out_q[0] !== 9'h17E) || err_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL resync: got beats=%0d first=%h errs=%0d, expected one beat 17e no errors",
               out_q.size(), (out_q.size() > 0) ? out_q[0] : 9'h0, err_q.size());
    end
    $display("[TB] timeout after %0d edges, resync delivered %0d byte", first_k, out_q.size());
  endtask

  task automatic test_backpressure_overflow();
    byte_q_t p = '{8'h11, 8'h22, 8'h33};
    int bad = 0;
    bit to;
    clear_obs();
    m_ready = 1'b0;
    send_frame(p, 8'h00, 0);
    exp_frame_cnt++;
    for (int i = 0; i < 20; i++) begin
      if ({m_valid, m_last, m_data} !== {1'b1, 1'b0, 8'h11}) bad++;
      if (i == 5) begin rx_data = 8'h55; rx_valid = 1'b1; end
      @(posedge clk); #1;
      rx_valid = 1'b0;
      rx_data = 8'h00;
    end
    tests_run++;
    if (bad !== 0) begin
      tests_failed++;
      $display("FAIL stall_hold: got %0d stalled cycles not showing v=1 l=0 d=11, expected 0", bad);
    end
    tests_run++;
    if (err_q.size() !== 1 || (err_q.size() == 1 && err_q[0] !== 2'd3)) begin
      tests_failed++;
      $display("FAIL overflow_err: got errs=%0d code=%0d, expected one pulse code 3",
               err_q.size(), (err_q.size() > 0) ? err_q[0] : 2'd0);
    end
    m_ready = 1'b1;
    wait_idle(20, to);
    tests_run++;
    if (to || beat_diffs(p) !== 0 || hold_viol !== 0 || frame_cnt !== 16'(exp_frame_cnt)) begin
      tests_failed++;
      $display("FAIL backpressure_drain: got timeout=%b diffs=%0d hold_viol=%0d cnt=%0d, expected 0 0 0 %0d",
               to, beat_diffs(p), hold_viol, frame_cnt, exp_frame_cnt);
    end
    $display("[TB] backpressure frame drained %0d bytes after stall", out_q.size());
  endtask

  task automatic test_reset_mid();
    byte_q_t p = '{8'h11, 8'h22, 8'h33};
    bit to;
    clear_obs();
    send_byte(8'h55); send_byte(8'hAA); send_byte(8'h03); send_byte(8'h11);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if ({m_data, m_valid, m_last, frame_ok, err_valid, err_code, frame_cnt, busy} !== '0) begin
      tests_failed++;
      $display("FAIL reset_mid_outputs: got v=%b ev=%b cnt=%0d busy=%b, expected all zero",
               m_valid, err_valid, frame_cnt, busy);
    end
    rst = 1'b0;
    exp_frame_cnt = 0;
    repeat (3) begin @(posedge clk); #1; end
    tests_run++;
    if (err_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_noerr: got %0d error pulses, expected 0", err_q.size());
    end
    send_frame(p, 8'h00, 0);
    exp_frame_cnt++;
    wait_idle(20, to);
    tests_run++;
    if (to || beat_diffs(p) !== 0 || frame_cnt !== 16'(exp_frame_cnt) || err_q.size() !== 0) begin
      tests_failed++;
      $display("FAIL reset_mid_reparse: got diffs=%0d cnt=%0d errs=%0d, expected 0 %0d 0",
               beat_diffs(p), frame_cnt, err_q.size(), exp_frame_cnt);
    end
    $display("[TB] reset mid-frame, next frame delivered %0d bytes", out_q.size());
  endtask

  task automatic test_random_frames();
    bit to;
    rand_ready = 1'b1;
    for (int n = 0; n < 30; n++) begin
      byte_q_t p;
      byte_q_t exp_out;
      bit good;
      int len;
      logic [7:0] x;
      len  = $urandom_range(1, MAX_LEN);
      good = ($urandom_range(0, 3) != 0);
      x    = good ? 8'h00 : 8'($urandom_range(1, 255));
      for (int i = 0; i < len; i++) p.push_back(8'($urandom));
      if (good) exp_out = p;
      clear_obs();
      send_frame(p, x, 3);
      if (good) exp_frame_cnt++;
      wait_idle(400, to);
      tests_run++;
      if (to || beat_diffs(exp_out) !== 0 || ok_cnt !== int'(good) ||
          err_q.size() !== int'(!good) || (!good && err_q.size() == 1 && err_q[0] !== 2'd1) ||
          frame_cnt !== 16'(exp_frame_cnt) || hold_viol !== 0 || both_cnt !== 0) begin
        tests_failed++;
        $display("FAIL random_frame%0d: got to=%b beats=%0d ok=%0d errs=%0d cnt=%0d hold=%0d both=%0d, expected beats=%0d ok=%0d errs=%0d cnt=%0d",
                 n, to, out_q.size(), ok_cnt, err_q.size(), frame_cnt, hold_viol, both_cnt,
                 exp_out.size(), int'(good), int'(!good), exp_frame_cnt);
      end
      $display("[TB] random frame %0d len=%0d good=%0d beats=%0d", n, len, good, out_q.size());
    end
    rand_ready = 1'b0;
    m_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_chk();
    test_len_bounds();
    test_timeout_resync();
    test_backpressure_overflow();
    test_reset_mid();
    test_random_frames();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
